syncramfifo_ram_resp: RTL and testbench

//  RAM-side responder for the double-width external-RAM FIFO port (wen/cen/addr/wdata/rdata).

---
 rtl/syncramfifo_pkg.sv | 29 ++
 rtl/syncramfifo_ram_resp_if.sv | 37 +++
 rtl/syncramfifo_ram_resp_array.sv | 44 ++++
 rtl/syncramfifo_ram_resp.sv | 201 ++++++++++++++++++++
 tb/tb_syncramfifo_ram_resp.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/syncramfifo_pkg.sv
// ----------------------------------------------------------------------------
// syncramfifo_pkg
// Shared types and helpers for the RAM-side responder of the double-width
// external-RAM FIFO port.
//   state_t   : responder FSM states (CLEAR = zero-fill running, READY)
//   CNT_W     : width of the access counters
//   CNT_MAX   : saturation value of the access counters
//   even_par  : even-parity bit of a (zero-extended) data half
// ----------------------------------------------------------------------------
package syncramfifo_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    localparam int              CNT_W   = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

    // Widest data half the parity helper accepts; callers zero-extend,
    // which leaves the parity unchanged.
    localparam int PAR_MAX_W = 256;

    // Even parity: the bit that makes the total number of ones even.
    function automatic logic even_par(input logic [PAR_MAX_W-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/syncramfifo_ram_resp_if.sv
// ----------------------------------------------------------------------------
// syncramfifo_ram_resp_if
// RAM port between the FIFO (master) and the RAM responder (slave).
//   cen        : chip enable, active low
//   wen        : write enable, active low
//   addr       : word address
//   wdata      : write data, 2*WID bits
//   inj_par    : store inverted parity on this write (parity builds only)
//   rdata      : registered read data
//   ready      : zero-fill complete, accesses honoured
//   acc_err    : one-cycle pulse after an illegal access
//   parity_err : parity mismatch on returned rdata
// ----------------------------------------------------------------------------
interface syncramfifo_ram_resp_if #(
    parameter int WID  = 32,
    parameter int AWID = 9
);
    logic            cen;
    logic            wen;
    logic [AWID-1:0] addr;
    logic [2*WID-1:0] wdata;
    logic            inj_par;
    logic [2*WID-1:0] rdata;
    logic            ready;
    logic            acc_err;
    logic            parity_err;

    modport master (
        output cen, wen, addr, wdata, inj_par,
        input  rdata, ready, acc_err, parity_err
    );

    modport slave (
        input  cen, wen, addr, wdata, inj_par,
        output rdata, ready, acc_err, parity_err
    );
endinterface

// File: rtl/syncramfifo_ram_resp_array.sv
// ----------------------------------------------------------------------------
// syncram_sp_array
// Single-port synchronous RAM, DEPTH x DW, registered read.
//   clk   : clock
//   rst   : synchronous active-high reset (clears the read register only)
//   en    : port enable
//   we    : write when en=1, read otherwise
//   addr  : word address, must be < DEPTH when en=1
//   wdata : write data
//   rdata : read data, valid the cycle after a read, held otherwise
// ----------------------------------------------------------------------------
module syncram_sp_array #(
    parameter int DW    = 64,
    parameter int DEPTH = 512,
    parameter int AWID  = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            we,
    input  logic [AWID-1:0] addr,
    input  logic [DW-1:0]   wdata,
    output logic [DW-1:0]   rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Storage has no reset so it maps onto block RAM; the owner zero-fills it.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    // Read register holds its value between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/syncramfifo_ram_resp.sv
// ----------------------------------------------------------------------------
// syncramfifo_ram_resp
// RAM-side responder for the double-width external-RAM FIFO port. Holds DEPTH
// words of 2*WID bits with a 1-cycle registered read, zero-fills itself after
// rst/softreset, flags illegal accesses and counts honoured reads/writes.
//   clk       : clock
//   rst       : synchronous active-high reset
//   softreset : restart zero-fill, clear counters
//   bus       : RAM port (slave side), see syncramfifo_ram_resp_if
//   wr_cnt    : honoured writes, saturating
//   rd_cnt    : honoured reads, saturating
// Optional feature macro: SYNCRAMFIFO_RAM_RESP_PARITY_EN adds a 2-bit parity
// side array and drives bus.parity_err; without it parity_err is 0 and
// bus.inj_par is ignored.
// ----------------------------------------------------------------------------
module syncramfifo_ram_resp
    import syncramfifo_pkg::*;
#(
    parameter int WID   = 32,
    parameter int DEPTH = 512,
    parameter int AWID  = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   softreset,
    syncramfifo_ram_resp_if.slave  bus,
    output logic [CNT_W-1:0]       wr_cnt,
    output logic [CNT_W-1:0]       rd_cnt
);

    localparam int              DW        = 2 * WID;
    localparam logic [AWID:0]   DEPTH_W   = (AWID + 1)'(DEPTH);
    localparam logic [AWID-1:0] FILL_LAST = AWID'(DEPTH - 1);

    state_t          state;
    state_t          state_nxt;
    logic [AWID-1:0] fill_addr;
    logic [AWID-1:0] fill_nxt;

    logic            ready;
    logic            in_range;
    logic            access;
    logic            honour;
    logic            wr_fire;
    logic            rd_fire;
    logic            illegal;

    logic            arr_en;
    logic            arr_we;
    logic [AWID-1:0] arr_addr;
    logic [DW-1:0]   arr_wdata;
    logic [DW-1:0]   arr_rdata;

    assign ready    = (state == READY);
    assign in_range = ({1'b0, bus.addr} < DEPTH_W);
    assign access   = !bus.cen;
    // An access in the softreset cycle is dropped: the memory is about to be
    // wiped anyway and the counters are being cleared.
    assign honour   = access && ready && in_range && !softreset;
    assign wr_fire  = honour && !bus.wen;
    assign rd_fire  = honour && bus.wen;
    assign illegal  = access && (!ready || !in_range);

    // State register and fill pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= CLEAR;
            fill_addr <= '0;
        end else begin
            state     <= state_nxt;
            fill_addr <= fill_nxt;
        end
    end

    // Next state and RAM port mux: the fill engine owns the port during CLEAR,
    // the external port owns it during READY.
    always_comb begin
        state_nxt = state;
        fill_nxt  = fill_addr;
        arr_en    = 1'b0;
        arr_we    = 1'b0;
        arr_addr  = bus.addr;
        arr_wdata = bus.wdata;
        case (state)
            CLEAR: begin
                arr_en    = 1'b1;
                arr_we    = 1'b1;
                arr_addr  = fill_addr;
                arr_wdata = '0;
                if (fill_addr == FILL_LAST) begin
                    state_nxt = READY;
                    fill_nxt  = '0;
                end else begin
                    fill_nxt  = fill_addr + AWID'(1);
                end
            end
            READY: begin
                arr_en = wr_fire || rd_fire;
                arr_we = wr_fire;
            end
            default: begin
                state_nxt = CLEAR;
                fill_nxt  = '0;
            end
        endcase
        if (softreset) begin
            state_nxt = CLEAR;
            fill_nxt  = '0;
        end
    end

    syncram_sp_array #(
        .DW   (DW),
        .DEPTH(DEPTH),
        .AWID (AWID)
    ) u_data (
        .clk  (clk),
        .rst  (rst),
        .en   (arr_en),
        .we   (arr_we),
        .addr (arr_addr),
        .wdata(arr_wdata),
        .rdata(arr_rdata)
    );

    assign bus.rdata = arr_rdata;
    assign bus.ready = ready;

    // Saturating access counters.
    always_ff @(posedge clk) begin
        if (rst || softreset) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else begin
            if (wr_fire && (wr_cnt != CNT_MAX)) begin
                wr_cnt <= wr_cnt + CNT_W'(1);
            end
            if (rd_fire && (rd_cnt != CNT_MAX)) begin
                rd_cnt <= rd_cnt + CNT_W'(1);
            end
        end
    end

    // Illegal access pulse, aligned with the cycle a read would return data.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.acc_err <= 1'b0;
        end else begin
            bus.acc_err <= illegal;
        end
    end

`ifdef SYNCRAMFIFO_RAM_RESP_PARITY_EN
    logic [1:0] par_wdata;
    logic [1:0] par_rdata;
    logic [1:0] par_calc;
    logic       rd_q;

    // Fill writes clean parity; inj_par inverts both stored bits.
    always_comb begin
        par_wdata = '0;
        if (state == READY) begin
            par_wdata = {even_par(PAR_MAX_W'(bus.wdata[DW-1:WID])),
                         even_par(PAR_MAX_W'(bus.wdata[WID-1:0]))}
                        ^ {2{bus.inj_par}};
        end
    end

    syncram_sp_array #(
        .DW   (2),
        .DEPTH(DEPTH),
        .AWID (AWID)
    ) u_par (
        .clk  (clk),
        .rst  (rst),
        .en   (arr_en),
        .we   (arr_we),
        .addr (arr_addr),
        .wdata(par_wdata),
        .rdata(par_rdata)
    );

    // Marks the cycle in which both read registers carry fresh data.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q <= 1'b0;
        end else begin
            rd_q <= rd_fire;
        end
    end

    assign par_calc       = {even_par(PAR_MAX_W'(arr_rdata[DW-1:WID])),
                             even_par(PAR_MAX_W'(arr_rdata[WID-1:0]))};
    assign bus.parity_err = rd_q && (par_calc != par_rdata);
`else
    logic unused_inj_par;
    assign unused_inj_par = bus.inj_par;
    assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_syncramfifo_ram_resp.sv
// ----------------------------------------------------------------------------
// tb_syncramfifo_ram_resp
// Self-checking bench for syncramfifo_ram_resp (WID=32, DEPTH=500). A memory
// model predicts read data; expected reads are queued when driven and popped
// when the DUT returns them. Define SYNCRAMFIFO_RAM_RESP_PARITY_EN to include
// the parity checks.
// ----------------------------------------------------------------------------
module tb_syncramfifo_ram_resp;
    import syncramfifo_pkg::*;

    localparam int WID   = 32;
    localparam int DEPTH = 500;
    localparam int AWID  = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             rst;
    logic             softreset;
    logic [CNT_W-1:0] wr_cnt;
    logic [CNT_W-1:0] rd_cnt;

    syncramfifo_ram_resp_if #(.WID(WID), .AWID(AWID)) bus ();

    syncramfifo_ram_resp #(
        .WID  (WID),
        .DEPTH(DEPTH),
        .AWID (AWID)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .softreset(softreset),
        .bus      (bus.slave),
        .wr_cnt   (wr_cnt),
        .rd_cnt   (rd_cnt)
    );

    always #5 clk = ~clk;

    int               cmp_count = 0;
    int               err_count = 0;
    logic [63:0]      model_mem [DEPTH];
    bit               model_par_bad [DEPTH];
    bit               model_ready;
    logic [15:0]      exp_wr;
    logic [15:0]      exp_rd;
    logic [63:0]      exp_rdata;
    logic [63:0]      rdata_q [$];
    bit               par_q [$];

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        cmp_count++;
        if (obs !== exp) begin
            err_count++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic modelClear();
        for (int i = 0; i < DEPTH; i++) begin
            model_mem[i]     = '0;
            model_par_bad[i] = 1'b0;
        end
        exp_wr      = '0;
        exp_rd      = '0;
        model_ready = 1'b0;
    endtask

    // One port cycle: drive at negedge, predict, check just after the edge.
    task automatic applyStimulus(input logic c, input logic w, input logic [AWID-1:0] a,
                                 input logic [63:0] d, input logic inj);
        logic legal;
        logic bad;
        bit   is_rd;
        @(negedge clk);
        bus.cen     = c;
        bus.wen     = w;
        bus.addr    = a;
        bus.wdata   = d;
        bus.inj_par = inj;
        bad   = !c && (!model_ready || (int'(a) >= DEPTH));
        legal = !c && !bad;
        is_rd = 1'b0;
        if (legal && !w) begin
            model_mem[a]     = d;
            model_par_bad[a] = inj;
            if (exp_wr != 16'hFFFF) exp_wr = exp_wr + 16'd1;
        end
        if (legal && w) begin
            rdata_q.push_back(model_mem[a]);
            par_q.push_back(model_par_bad[a]);
            is_rd = 1'b1;
            if (exp_rd != 16'hFFFF) exp_rd = exp_rd + 16'd1;
        end
        @(posedge clk);
        #1;
        bus.cen = 1'b1;
        if (is_rd) begin
            exp_rdata = rdata_q.pop_front();
            checkOutput("rdata", bus.rdata, exp_rdata);
`ifdef SYNCRAMFIFO_RAM_RESP_PARITY_EN
            checkOutput("parity_err", 64'(bus.parity_err), 64'(par_q.pop_front()));
`else
            void'(par_q.pop_front());
            checkOutput("parity_err", 64'(bus.parity_err), 64'(1'b0));
`endif
        end else begin
            checkOutput("parity_idle", 64'(bus.parity_err), 64'(1'b0));
        end
        checkOutput("acc_err", 64'(bus.acc_err), 64'(bad));
    endtask

    task automatic waitReady(input int max_cycles, output int cycles);
        cycles = 0;
        while (!bus.ready && cycles < max_cycles) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        checkOutput("ready_wait", 64'(bus.ready), 64'(1'b1));
        model_ready = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc;
        rst         = 1'b1;
        softreset   = 1'b0;
        bus.cen     = 1'b1;
        bus.wen     = 1'b1;
        bus.addr    = '0;
        bus.wdata   = '0;
        bus.inj_par = 1'b0;
        modelClear();
        exp_rdata   = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_rdata", bus.rdata, 64'h0);
        checkOutput("rst_ready", 64'(bus.ready), 64'(1'b0));
        checkOutput("rst_acc_err", 64'(bus.acc_err), 64'(1'b0));
        checkOutput("rst_wr_cnt", 64'(wr_cnt), 64'h0);
        checkOutput("rst_rd_cnt", 64'(rd_cnt), 64'h0);
        checkOutput("rst_parity_err", 64'(bus.parity_err), 64'(1'b0));
        rst = 1'b0;

        // Zero-fill lasts exactly DEPTH cycles
        waitReady(DEPTH + 20, cyc);
        checkOutput("fill_cycles", 64'(cyc), 64'(DEPTH));
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, AWID'(i), 64'h0, 1'b0);

        // Write then read back
        applyStimulus(1'b0, 1'b0, AWID'(5), 64'hDEAD_BEEF_0123_4567, 1'b0);
        applyStimulus(1'b0, 1'b1, AWID'(5), 64'h0, 1'b0);
        checkOutput("wr_cnt_t2", 64'(wr_cnt), 64'(exp_wr));
        checkOutput("rd_cnt_t2", 64'(rd_cnt), 64'(exp_rd));
        applyStimulus(1'b0, 1'b0, AWID'(6), 64'hA5A5_5A5A_FFFF_0000, 1'b0);
        applyStimulus(1'b1, 1'b1, AWID'(0), 64'h0, 1'b0);
        applyStimulus(1'b0, 1'b1, AWID'(6), 64'h0, 1'b0);

        // Out-of-range accesses: pulse only, nothing else moves
        applyStimulus(1'b0, 1'b0, AWID'(DEPTH), 64'h1111_2222_3333_4444, 1'b0);
        applyStimulus(1'b1, 1'b1, AWID'(0), 64'h0, 1'b0);
        applyStimulus(1'b0, 1'b1, AWID'(510), 64'h0, 1'b0);
        checkOutput("oob_rdata_hold", bus.rdata, exp_rdata);
        checkOutput("oob_wr_cnt", 64'(wr_cnt), 64'(exp_wr));
        checkOutput("oob_rd_cnt", 64'(rd_cnt), 64'(exp_rd));

        // Softreset mid-stream, access during refill, refill wipes memory
        applyStimulus(1'b0, 1'b0, AWID'(7), 64'h7777_8888_9999_AAAA, 1'b0);
        @(negedge clk);
        softreset = 1'b1;
        @(posedge clk);
        #1;
        softreset = 1'b0;
        modelClear();
        checkOutput("sr_ready", 64'(bus.ready), 64'(1'b0));
        checkOutput("sr_wr_cnt", 64'(wr_cnt), 64'h0);
        checkOutput("sr_rd_cnt", 64'(rd_cnt), 64'h0);
        applyStimulus(1'b0, 1'b1, AWID'(3), 64'h0, 1'b0);
        applyStimulus(1'b1, 1'b1, AWID'(0), 64'h0, 1'b0);
        checkOutput("busy_rdata_hold", bus.rdata, exp_rdata);
        waitReady(DEPTH + 20, cyc);
        checkOutput("refill_cycles", 64'(cyc), 64'(DEPTH - 2));
        applyStimulus(1'b0, 1'b1, AWID'(7), 64'h0, 1'b0);

`ifdef SYNCRAMFIFO_RAM_RESP_PARITY_EN
        // Parity injection
        applyStimulus(1'b0, 1'b0, AWID'(9), 64'h0F0F_1234_8000_0001, 1'b1);
        applyStimulus(1'b0, 1'b0, AWID'(10), 64'h0F0F_1234_8000_0001, 1'b0);
        applyStimulus(1'b0, 1'b1, AWID'(9), 64'h0, 1'b0);
        applyStimulus(1'b0, 1'b1, AWID'(10), 64'h0, 1'b0);
        applyStimulus(1'b1, 1'b1, AWID'(0), 64'h0, 1'b0);
`endif

        // Read counter saturation
        applyStimulus(1'b0, 1'b0, AWID'(11), 64'hCAFE_F00D_1357_9BDF, 1'b0);
        for (int i = 0; i < 70000; i++) begin
            applyStimulus(1'b0, 1'b1, AWID'((i * 7) % DEPTH), 64'h0, 1'b0);
            if (i == 65533) begin
                checkOutput("rd_cnt_near_max", 64'(rd_cnt), 64'(exp_rd));
            end
        end
        checkOutput("rd_cnt_sat", 64'(rd_cnt), 64'(16'hFFFF));
        checkOutput("wr_cnt_end", 64'(wr_cnt), 64'(exp_wr));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
        $finish;
    end

endmodule
